// File: rtl/parity_engine.sv
// rtl/parity_engine.sv - parity generator/checker with one-deep output register
// Optional error counter and sticky flag: define PARITY_ENGINE_ERR_CNT_EN.
module parity_engine #(
  parameter int WIDTH_DATA = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH_DATA-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  IN_MODE,
  input  logic [1:0]            PAR_TYP,
  input  logic                  PAR_EN,
  input  logic                  RX_PAR_BIT,
  output logic [WIDTH_DATA-1:0] OUT_DATA,
  output logic                  OUT_PAR_BIT,
  output logic                  OUT_PAR_ERR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  input  logic                  CNT_CLR,
  output logic [CNT_W-1:0]      ERR_CNT,
  output logic                  STICKY_ERR
);

  localparam logic [1:0] TYP_EVEN = 2'b00;
  localparam logic [1:0] TYP_ODD  = 2'b01;
  localparam logic [1:0] TYP_MARK = 2'b10;

  logic [WIDTH_DATA-1:0] r_out_data;
  logic                  r_out_par_bit;
  logic                  r_out_par_err;
  logic                  r_out_valid;

  logic w_in_ready;
  logic w_accept;
  logic w_exp;
  logic w_err;

  // A full register may be drained and refilled on the same edge.
  assign w_in_ready = !r_out_valid || OUT_READY;
  assign w_accept   = IN_VALID && w_in_ready;

  always_comb begin
    w_exp = 1'b0;
    if (PAR_EN) begin
      case (PAR_TYP)
        TYP_EVEN: w_exp = ^IN_DATA;
        TYP_ODD:  w_exp = ~^IN_DATA;
        TYP_MARK: w_exp = 1'b1;
        default:  w_exp = 1'b0;
      endcase
    end
  end

  assign w_err = IN_MODE && PAR_EN && (RX_PAR_BIT != w_exp);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_par_bit <= 1'b0;
      r_out_par_err <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= IN_DATA;
      r_out_par_bit <= w_exp;
      r_out_par_err <= w_err;
    end else if (OUT_READY) begin
      r_out_valid   <= 1'b0;
    end
  end

`ifdef PARITY_ENGINE_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_sticky_err;

  // Clear beats a coincident error; the counter never wraps.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      r_err_cnt    <= '0;
      r_sticky_err <= 1'b0;
    end else if (w_accept && w_err) begin
      if (r_err_cnt != {CNT_W{1'b1}}) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      r_sticky_err <= 1'b1;
    end
  end

  assign ERR_CNT    = r_err_cnt;
  assign STICKY_ERR = r_sticky_err;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = CNT_CLR;
  assign ERR_CNT          = '0;
  assign STICKY_ERR       = 1'b0;
`endif

  assign IN_READY    = w_in_ready;
  assign OUT_DATA    = r_out_data;
  assign OUT_PAR_BIT = r_out_par_bit;
  assign OUT_PAR_ERR = r_out_par_err;
  assign OUT_VALID   = r_out_valid;

endmodule

// File: tb/tb_parity_engine.sv
// tb/tb_parity_engine.sv - self-checking bench for parity_engine
module tb_parity_engine;

  localparam int WD = 8;
  localparam int CW = 2;

`ifdef PARITY_ENGINE_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [WD-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_MODE;
  logic [1:0]    PAR_TYP;
  logic          PAR_EN;
  logic          RX_PAR_BIT;
  logic [WD-1:0] OUT_DATA;
  logic          OUT_PAR_BIT;
  logic          OUT_PAR_ERR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          CNT_CLR;
  logic [CW-1:0] ERR_CNT;
  logic          STICKY_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic          m_valid  = 1'b0;
  logic [WD-1:0] m_data   = '0;
  logic          m_par    = 1'b0;
  logic          m_err    = 1'b0;
  int            m_cnt    = 0;
  logic          m_sticky = 1'b0;

  always #5 CLK = ~CLK;

  parity_engine #(.WIDTH_DATA(WD), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_MODE(IN_MODE), .PAR_TYP(PAR_TYP), .PAR_EN(PAR_EN), .RX_PAR_BIT(RX_PAR_BIT),
    .OUT_DATA(OUT_DATA), .OUT_PAR_BIT(OUT_PAR_BIT), .OUT_PAR_ERR(OUT_PAR_ERR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .CNT_CLR(CNT_CLR), .ERR_CNT(ERR_CNT), .STICKY_ERR(STICKY_ERR)
  );

  function automatic logic exp_par(logic [WD-1:0] d, logic [1:0] t, logic en);
    int ones;
    ones = $countones(d);
    if (!en) return 1'b0;
    case (t)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [CW-1:0] c;
    c = m_cnt[CW-1:0];
    return {m_valid, m_data, m_par, m_err, c, m_sticky, (!m_valid || OUT_READY)};
  endfunction

  // One clock edge; the model advances from the inputs seen before the edge.
  task automatic tick();
    logic          acc, p, e, rst, clr, ordy;
    logic [WD-1:0] d;
    int            cmax;
    cmax = (1 << CW) - 1;
    acc  = IN_VALID && (!m_valid || OUT_READY);
    p    = exp_par(IN_DATA, PAR_TYP, PAR_EN);
    e    = IN_MODE && PAR_EN && (RX_PAR_BIT != p);
    d    = IN_DATA;
    rst  = RST;
    clr  = CNT_CLR;
    ordy = OUT_READY;
    @(posedge CLK);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_par = 1'b0; m_err = 1'b0;
      m_cnt = 0; m_sticky = 1'b0;
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_data = d; m_par = p; m_err = e;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (CNT_ON) begin
        if (clr) begin
          m_cnt = 0; m_sticky = 1'b0;
        end else if (acc && e) begin
          if (m_cnt < cmax) m_cnt++;
          m_sticky = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'hFF; IN_MODE = 1'b1; PAR_TYP = 2'd0;
    PAR_EN = 1'b1; RX_PAR_BIT = 1'b1; OUT_READY = 1'b0; CNT_CLR = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR, ERR_CNT, STICKY_ERR} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b d=%h p=%b e=%b cnt=%0d st=%b, want all 0",
               OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR, ERR_CNT, STICKY_ERR);
    end
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
    tick();
  endtask

  task automatic test_generate();
    logic [3:0] want_bits;
    want_bits = 4'b0101;
    IN_VALID = 1'b1; IN_DATA = 8'hA7; IN_MODE = 1'b0; PAR_EN = 1'b1; OUT_READY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      PAR_TYP = t[1:0];
      RX_PAR_BIT = 1'($urandom);
      tick();
      n_cmp++;
      if ({OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR} !== {1'b1, 8'hA7, want_bits[t], 1'b0}) begin
        n_bad++;
        $display("FAIL generate_typ%0d: got v=%b d=%h p=%b e=%b want v=1 d=a7 p=%b e=0",
                 t, OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR, want_bits[t]);
      end
    end
    IN_VALID = 1'b0;
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL generate_drain: got OUT_VALID=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_check();
    logic [CW-1:0] wc;
    CNT_CLR = 1'b1; IN_VALID = 1'b0;
    tick();
    CNT_CLR = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 8'h03; PAR_TYP = 2'd0; IN_MODE = 1'b1; PAR_EN = 1'b1;
    RX_PAR_BIT = 1'b1; OUT_READY = 1'b1;
    wc = CNT_ON ? CW'(1) : CW'(0);
    tick();
    n_cmp++;
    if ({OUT_PAR_ERR, ERR_CNT, STICKY_ERR} !== {1'b1, wc, CNT_ON}) begin
      n_bad++;
      $display("FAIL check_err: got e=%b cnt=%0d st=%b want e=1 cnt=%0d st=%b",
               OUT_PAR_ERR, ERR_CNT, STICKY_ERR, wc, CNT_ON);
    end
    RX_PAR_BIT = 1'b0;
    tick();
    n_cmp++;
    if ({OUT_PAR_ERR, ERR_CNT, STICKY_ERR} !== {1'b0, wc, CNT_ON}) begin
      n_bad++;
      $display("FAIL check_ok: got e=%b cnt=%0d st=%b want e=0 cnt=%0d st=%b",
               OUT_PAR_ERR, ERR_CNT, STICKY_ERR, wc, CNT_ON);
    end
    RX_PAR_BIT = 1'b1; PAR_EN = 1'b0;
    tick();
    n_cmp++;
    if ({OUT_PAR_BIT, OUT_PAR_ERR, ERR_CNT} !== {1'b0, 1'b0, wc}) begin
      n_bad++;
      $display("FAIL check_par_dis: got p=%b e=%b cnt=%0d want p=0 e=0 cnt=%0d",
               OUT_PAR_BIT, OUT_PAR_ERR, ERR_CNT, wc);
    end
    IN_VALID = 1'b0; PAR_EN = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    IN_VALID = 1'b1; IN_DATA = 8'h5C; PAR_TYP = 2'd1; IN_MODE = 1'b0; PAR_EN = 1'b1;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0; IN_DATA = 8'h81;
    for (int i = 0; i < 3; i++) begin
      PAR_TYP = 2'(i + 2);
      tick();
      n_cmp++;
      if ({IN_READY, OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR} !== {1'b0, 1'b1, 8'h5C, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL backpressure_hold%0d: got rdy=%b v=%b d=%h p=%b e=%b want rdy=0 v=1 d=5c p=1 e=0",
                 i, IN_READY, OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR);
      end
    end
    OUT_READY = 1'b1; PAR_TYP = 2'd0;
    #1;
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_ready: got %b want 1", IN_READY);
    end
    tick();
    n_cmp++;
    if ({OUT_VALID, OUT_DATA, OUT_PAR_BIT} !== {1'b1, 8'h81, 1'b0}) begin
      n_bad++;
      $display("FAIL backpressure_refill: got v=%b d=%h p=%b want v=1 d=81 p=0",
               OUT_VALID, OUT_DATA, OUT_PAR_BIT);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    logic [CW-1:0] wc;
    CNT_CLR = 1'b1; IN_VALID = 1'b0;
    tick();
    CNT_CLR = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 8'h03; PAR_TYP = 2'd0; IN_MODE = 1'b1; PAR_EN = 1'b1;
    RX_PAR_BIT = 1'b1; OUT_READY = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      wc = CNT_ON ? CW'((k > 3) ? 3 : k) : CW'(0);
      n_cmp++;
      if ({ERR_CNT, STICKY_ERR} !== {wc, CNT_ON}) begin
        n_bad++;
        $display("FAIL saturate_err%0d: got cnt=%0d st=%b want cnt=%0d st=%b",
                 k, ERR_CNT, STICKY_ERR, wc, CNT_ON);
      end
    end
    CNT_CLR = 1'b1;
    tick();
    n_cmp++;
    if ({OUT_PAR_ERR, ERR_CNT, STICKY_ERR} !== {1'b1, CW'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL clear_wins: got e=%b cnt=%0d st=%b want e=1 cnt=0 st=0",
               OUT_PAR_ERR, ERR_CNT, STICKY_ERR);
    end
    CNT_CLR = 1'b0; IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [14:0] got;
    logic [14:0] want;
    for (int i = 0; i < 600; i++) begin
      RST        = ($urandom_range(0, 49) == 0);
      IN_VALID   = ($urandom_range(0, 9) < 7);
      OUT_READY  = ($urandom_range(0, 9) < 6);
      CNT_CLR    = ($urandom_range(0, 29) == 0);
      IN_DATA    = 8'($urandom);
      IN_MODE    = 1'($urandom);
      PAR_TYP    = 2'($urandom);
      PAR_EN     = ($urandom_range(0, 3) != 0);
      RX_PAR_BIT = 1'($urandom);
      tick();
      got  = {OUT_VALID, OUT_DATA, OUT_PAR_BIT, OUT_PAR_ERR, ERR_CNT, STICKY_ERR, IN_READY};
      want = exp_vec();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got {v,d,p,e,cnt,st,rdy}=%h want %h", i, got, want);
      end
    end
    RST = 1'b0; IN_VALID = 1'b0; CNT_CLR = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_backpressure();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
